// File: rtl/exec_unit.sv
// exec_unit: RV32I/RV64I execute stage. It computes ALU, compare, shift,
// LUI/AUIPC/LINK results and runs byte/half/word loads and stores over a
// request/acknowledge data-memory port that may insert wait states.
// Optional feature macro: EXEC_MISALIGN_TRAP_EN traps misaligned half/word
// accesses without issuing a request.
module exec_unit #(
  parameter int XLEN        = 32,
  parameter int PC_STEP     = 4,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [4:0]        op,
  input  logic              use_imm,
  input  logic [XLEN-1:0]   rs1,
  input  logic [XLEN-1:0]   rs2,
  input  logic [XLEN-1:0]   imm,
  input  logic [XLEN-1:0]   pc,
  output logic              busy,
  output logic              done,
  output logic [XLEN-1:0]   result,
  output logic              err,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  output logic [XLEN/8-1:0] dmem_be,
  input  logic [XLEN-1:0]   dmem_rdata,
  input  logic              dmem_ack
);
  localparam int SHW = $clog2(XLEN);
  localparam int LB  = $clog2(XLEN/8);
  localparam int NB  = XLEN/8;
  localparam int TW  = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TO_LAST = (MEM_TIMEOUT > 0) ? TW'(MEM_TIMEOUT - 1) : '0;
  localparam bit TO_EN = (MEM_TIMEOUT > 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_MEM  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]      state;
  logic [4:0]      op_q;
  logic            use_imm_q;
  logic [XLEN-1:0] rs1_q, rs2_q, imm_q, pc_q;
  logic [TW-1:0]   wcnt;

  logic [XLEN-1:0] opb, alu_res, addr, st_val, ld_sh, ld_res;
  logic [SHW-1:0]  shamt;
  logic [LB-1:0]   off;
  logic [1:0]      size;
  logic [NB-1:0]   be_base;
  logic            illegal, misalign, is_store;

  // ALU / upper-immediate / link result for the EXEC state
  always_comb begin
    opb     = use_imm_q ? imm_q : rs2_q;
    shamt   = opb[SHW-1:0];
    illegal = 1'b0;
    alu_res = '0;
    case (op_q)
      5'd0:  alu_res = rs1_q + opb;
      5'd1:  alu_res = rs1_q - opb;
      5'd2:  alu_res = rs1_q ^ opb;
      5'd3:  alu_res = rs1_q | opb;
      5'd4:  alu_res = rs1_q & opb;
      5'd5:  alu_res = rs1_q << shamt;
      5'd6:  alu_res = rs1_q >> shamt;
      5'd7:  alu_res = $unsigned($signed(rs1_q) >>> shamt);
      5'd8:  alu_res = {{(XLEN-1){1'b0}}, $signed(rs1_q) < $signed(opb)};
      5'd9:  alu_res = {{(XLEN-1){1'b0}}, rs1_q < opb};
      5'd18: alu_res = pc_q + XLEN'(PC_STEP);
      5'd19: alu_res = imm_q << 12;
      5'd20: alu_res = pc_q + (imm_q << 12);
      default: illegal = 1'b1;
    endcase
  end

  // Address, byte lanes, store data placement and load extraction
  always_comb begin
    addr     = rs1_q + imm_q;
    off      = addr[LB-1:0];
    is_store = (op_q >= 5'd15);
    case (op_q)
      5'd11, 5'd14, 5'd16: size = 2'd1;
      5'd12, 5'd17:        size = 2'd2;
      default:             size = 2'd0;
    endcase
    case (size)
      2'd1:    be_base = NB'(4'b0011);
      2'd2:    be_base = NB'(4'b1111);
      default: be_base = NB'(4'b0001);
    endcase
    case (size)
      2'd1:    st_val = XLEN'(rs2_q[15:0]);
      2'd2:    st_val = XLEN'(rs2_q[31:0]);
      default: st_val = XLEN'(rs2_q[7:0]);
    endcase
    misalign = ((size == 2'd1) && addr[0]) || ((size == 2'd2) && (addr[1:0] != 2'b00));
    ld_sh    = dmem_rdata >> {off, 3'b000};
    case (op_q)
      5'd10:   ld_res = {{(XLEN-8){ld_sh[7]}}, ld_sh[7:0]};
      5'd11:   ld_res = {{(XLEN-16){ld_sh[15]}}, ld_sh[15:0]};
      5'd13:   ld_res = XLEN'(ld_sh[7:0]);
      5'd14:   ld_res = XLEN'(ld_sh[15:0]);
      default: ld_res = (XLEN == 32) ? ld_sh : {{(XLEN-32){ld_sh[31]}}, ld_sh[31:0]};
    endcase
  end

  // Control FSM plus registered outputs and memory request
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      op_q       <= '0;
      use_imm_q  <= 1'b0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      imm_q      <= '0;
      pc_q       <= '0;
      wcnt       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
      err        <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_be    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          op_q      <= op;
          use_imm_q <= use_imm;
          rs1_q     <= rs1;
          rs2_q     <= rs2;
          imm_q     <= imm;
          pc_q      <= pc;
          busy      <= 1'b1;
          state     <= (op >= 5'd10 && op <= 5'd17) ? S_MEM : S_EXEC;
        end
        S_EXEC: begin
          result <= alu_res;
          err    <= illegal;
          busy   <= 1'b0;
          state  <= S_DONE;
        end
        S_MEM: begin
          if (!dmem_req) begin
            // first MEM cycle: set up the request (ack is ignored while req is low)
`ifdef EXEC_MISALIGN_TRAP_EN
            if (misalign) begin
              result <= '0;
              err    <= 1'b1;
              busy   <= 1'b0;
              state  <= S_DONE;
            end else
`endif
            begin
              dmem_req   <= 1'b1;
              dmem_we    <= is_store;
              dmem_addr  <= addr;
              dmem_be    <= NB'(be_base << off);
              dmem_wdata <= st_val << {off, 3'b000};
              wcnt       <= '0;
            end
          end else if (dmem_ack) begin
            dmem_req <= 1'b0;
            result   <= is_store ? st_val : ld_res;
            err      <= 1'b0;
            busy     <= 1'b0;
            state    <= S_DONE;
          end else if (TO_EN && wcnt == TO_LAST) begin
            dmem_req <= 1'b0;
            result   <= '0;
            err      <= 1'b1;
            busy     <= 1'b0;
            state    <= S_DONE;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        default: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // misalign is only consumed when the trap is built in
  logic unused_ok;
  assign unused_ok = misalign;
endmodule

// File: doc/exec_unit.md
# exec_unit

Parametrised, handshaked execute stage for the RV32I core: computes ALU, compare, shift, upper-immediate and link results, and runs byte/half/word loads and stores over a request/acknowledge data-memory port with wait states. It sits between decode/register-read and writeback.
- Accepts one operation per `start` pulse.
- Reports completion with a single-cycle `done` pulse and holds `result` until the next accept.
- Uses signed compares, arithmetic right shift, sign/zero-extended loads, byte-lane placement, a memory timeout and an optional misalignment trap.

## Interface
- `XLEN`, 32: datapath width; legal values 32 or 64. `SHW = $clog2(XLEN)`, `LB = $clog2(XLEN/8)`.
- `PC_STEP`, 4: value added to `pc` for the link result.
- `MEM_TIMEOUT`, 16: maximum wait cycles for `dmem_ack`; 0 disables the timeout.

Ports:
- `clk` in 1: clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: operation valid; accepted only in IDLE.
- `op` in 5: operation code:
  - 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU
  - 10 LB, 11 LH, 12 LW, 13 LBU, 14 LHU, 15 SB, 16 SH, 17 SW
  - 18 LINK, 19 LUI, 20 AUIPC
  - 21–31 illegal
- `use_imm` in 1: operand B = `imm` instead of `rs2`; applies to ops 0–9.
- `rs1`, `rs2`, `imm`, `pc` in XLEN: operands; sampled at accept.
- `busy` out 1: high from the cycle after accept until `done`.
- `done` out 1: one-cycle completion pulse.
- `result` out XLEN: operation result.
- `err` out 1: valid with `done`; illegal op, timeout or misalignment.
- `dmem_req` out 1, `dmem_we` out 1, `dmem_addr` out XLEN, `dmem_wdata` out XLEN, `dmem_be` out XLEN/8: memory request.
- `dmem_rdata` in XLEN, `dmem_ack` in 1: memory response.

## Operation
- **FSM states:** IDLE, EXEC, MEM, DONE.
- **IDLE:**
  - If `start`, capture `op`/`use_imm`/`rs1`/`rs2`/`imm`/`pc`.
  - Go to MEM for ops 10–17; otherwise go to EXEC.
- **EXEC:**
  - Compute the result; go to DONE.
  - Illegal op: `result`=0, `err`=1.
- **Arithmetic rules:**
  - All results are computed modulo 2^XLEN.
  - Shift amount is B[SHW-1:0].
  - SRA replicates the sign bit.
  - SLT is a signed compare; SLTU is unsigned; both return 0/1.
  - LUI = `imm`<<12; AUIPC = `pc`+(`imm`<<12); LINK = `pc`+PC_STEP.
- **MEM:**
  - `dmem_addr`=`rs1`+`imm`; `off`=addr[LB-1:0].
  - `dmem_be` has 1/2/4 lanes set, starting at `off`.
  - Store data is shifted left by 8·`off`.
  - `dmem_req` stays high with all request fields stable until `dmem_ack` is sampled high.
  - On ack, the load result is `dmem_rdata`>>8·`off`, truncated to 8/16/32 bits and sign-extended (LB/LH/LW) or zero-extended (LBU/LHU).
  - Store `result` = stored value (`rs2` truncated, zero-extended).
  - Go to DONE.
- **Timeout:**
  - Wait counter increments every MEM cycle without ack.
  - When it reaches MEM_TIMEOUT: drop `dmem_req`, set `result`=0, `err`=1, go to DONE.
- **DONE:**
  - `done`=1 for one cycle, then IDLE.
  - `result`/`err` hold until the next accept.
- **`start` handling:** `start` while not in IDLE is ignored and not queued.
- **Reset:** IDLE; all outputs 0 (`result`, `err`, `busy`, `done`, `dmem_*`). Applies mid-transaction too:
  - `dmem_req` falls on the reset edge.
  - No `done` is issued for the aborted operation.

## Timing
- **ALU/LINK/LUI/AUIPC/illegal:** accept at edge N; `done` high after edge N+2 (2-cycle latency); `busy` high for one cycle.
- **Memory:**
  - `dmem_req` high after edge N+1.
  - `dmem_ack` sampled at edge M (M ≥ N+2) ends the request; `dmem_req` is low after M.
  - `done` high after edge M+1.
  - With zero wait states the latency is 3 cycles.
- `dmem_ack` while `dmem_req`=0 is ignored.
- Back-to-back: `start` in the DONE cycle is ignored. The earliest next accept is the first IDLE cycle.

## Configuration
- `EXEC_MISALIGN_TRAP_EN`
  - **Defined:**
    - LH/LHU/SH with addr[0]≠0, or LW/SW with addr[1:0]≠0, skip the memory access entirely (`dmem_req` never rises).
    - MEM exits to DONE after one cycle with `result`=0, `err`=1.
  - **Undefined:** no check is made; the access is issued with the computed `dmem_be`. Byte lanes beyond the word are dropped.

## Test plan
- **Reset:** `rst` held 2 cycles mid-SW with `dmem_req` high -> `dmem_req`=0 next cycle, no `done`, all outputs 0.
- **Signed ALU:** SRA `rs1`=0x80000010, B=4 -> `result`=0xF8000001. SLT −1 vs 1 -> 1. SLTU same operands -> 0. `done` 2 cycles after accept.
- **Sign-extended load:** LB addr=0x103 (`rs1`=0x100, `imm`=3), `dmem_rdata`=0x80000000, ack after 3 wait cycles -> `dmem_be`=0b1000, `result`=0xFFFFFF80, `done` the cycle after ack.
- **Byte store:** SB `rs2`=0x12345678 to addr 0x202 -> `dmem_we`=1, `dmem_be`=0b0100, `dmem_wdata`=0x00780000, `result`=0x78.
- **Timeout:** LW with `dmem_ack` never asserted, MEM_TIMEOUT=16 -> `dmem_req` drops after 16 cycles, `err`=1, `result`=0. Also check that `start` pulsed while busy is ignored.
- **Misalignment:** LW to 0x102 with the macro defined -> `err`=1, no request. Without the macro -> request issued with `dmem_be`=0b1100.
